// File: rtl/gb_timer_accurate_if.sv
// CPU-side bus bundle for the timer block: address/data/strobe plus the
// timer interrupt request/acknowledge pair.
interface gb_timer_accurate_if;
  logic [15:0] a;
  logic [7:0]  din;
  logic        wr;
  logic [7:0]  dout;
  logic        int_tim_req;
  logic        int_tim_ack;

  modport master (
    output a, din, wr, int_tim_ack,
    input  dout, int_tim_req
  );

  modport slave (
    input  a, din, wr, int_tim_ack,
    output dout, int_tim_req
  );
endinterface

// File: rtl/gb_timer_accurate.sv
// GameBoy DIV/TIMA/TMA/TAC timer with falling-edge TIMA clocking, DIV/TAC
// write glitches, delayed overflow reload and interrupt request/ack.
module gb_timer_accurate #(
  parameter logic [15:0] BASE_ADDR      = 16'hFF04,
  parameter int unsigned DIV_BITS       = 16,
  parameter int unsigned CLK_PER_MCYCLE = 4,
  parameter int unsigned TAP0           = 9,
  parameter int unsigned TAP1           = 3,
  parameter int unsigned TAP2           = 5,
  parameter int unsigned TAP3           = 7
) (
  input logic                clk,
  input logic                rst,
  gb_timer_accurate_if.slave bus
);

  localparam int unsigned CntW = (CLK_PER_MCYCLE > 2) ? $clog2(CLK_PER_MCYCLE) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(CLK_PER_MCYCLE - 1);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StOvf    = 2'd1;
  localparam logic [1:0] StReload = 2'd2;

  logic [DIV_BITS-1:0] div_q, div_d;
  logic [7:0]          tima_q, tima_d;
  logic [7:0]          tma_q, tma_d;
  logic [2:0]          tac_q, tac_d;
  logic [1:0]          state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                t_prev_q;
  logic                irq_q, irq_d;
  logic                irq_set;

  logic sel_div, sel_tima, sel_tma, sel_tac;
  logic we_div, we_tima, we_tma, we_tac;
  logic tap_bit, t, fall;
  logic [8:0] tima_inc;

  assign sel_div  = (bus.a == BASE_ADDR);
  assign sel_tima = (bus.a == BASE_ADDR + 16'd1);
  assign sel_tma  = (bus.a == BASE_ADDR + 16'd2);
  assign sel_tac  = (bus.a == BASE_ADDR + 16'd3);

  assign we_div  = bus.wr & sel_div;
  assign we_tima = bus.wr & sel_tima;
  assign we_tma  = bus.wr & sel_tma;
  assign we_tac  = bus.wr & sel_tac;

  // Select the divider tap feeding the timer input.
  always_comb begin
    case (tac_q[1:0])
      2'b00:   tap_bit = div_q[TAP0];
      2'b01:   tap_bit = div_q[TAP1];
      2'b10:   tap_bit = div_q[TAP2];
      default: tap_bit = div_q[TAP3];
    endcase
  end

  // Any drop of t counts, including ones caused by DIV clears or TAC writes.
  assign t        = tac_q[2] & tap_bit;
  assign fall     = t_prev_q & ~t;
  assign tima_inc = {1'b0, tima_q} + 9'd1;

  // Next-state logic for divider, registers, overflow FSM and interrupt.
  always_comb begin
    div_d   = we_div ? '0 : div_q + DIV_BITS'(1);
    tma_d   = we_tma ? bus.din : tma_q;
    tac_d   = we_tac ? bus.din[2:0] : tac_q;
    tima_d  = tima_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    irq_set = 1'b0;
    case (state_q)
      StIdle: begin
        if (we_tima) begin
          tima_d = bus.din;
        end else if (fall) begin
          tima_d = tima_inc[7:0];
          if (tima_inc[8]) begin
            state_d = StOvf;
            cnt_d   = '0;
          end
        end
      end
      StOvf: begin
        if (we_tima) begin
          // CPU write cancels the pending reload and its interrupt.
          tima_d  = bus.din;
          state_d = StIdle;
        end else if (cnt_q == CntLast) begin
          tima_d  = tma_q;
          irq_set = 1'b1;
          state_d = StReload;
        end else begin
          cnt_d = cnt_q + CntW'(1);
          if (fall) tima_d = tima_inc[7:0];
        end
      end
      StReload: begin
        // TIMA writes and edges are dropped; a TMA write forwards into TIMA.
        if (we_tma) tima_d = bus.din;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    irq_d = irq_set | (irq_q & ~bus.int_tim_ack);
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q    <= '0;
      tima_q   <= '0;
      tma_q    <= '0;
      tac_q    <= '0;
      state_q  <= StIdle;
      cnt_q    <= '0;
      t_prev_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      div_q    <= div_d;
      tima_q   <= tima_d;
      tma_q    <= tma_d;
      tac_q    <= tac_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      t_prev_q <= t;
      irq_q    <= irq_d;
    end
  end

  // Combinational read mux.
  always_comb begin
    bus.dout = 8'hFF;
    if (sel_div)  bus.dout = div_q[DIV_BITS-1 -: 8];
    if (sel_tima) bus.dout = tima_q;
    if (sel_tma)  bus.dout = tma_q;
    if (sel_tac)  bus.dout = {5'b11111, tac_q};
  end

  assign bus.int_tim_req = irq_q;

endmodule

// File: tb/tb_gb_timer_accurate.sv
// Self-checking bench for gb_timer_accurate: scenario expectations are queued
// and compared against register reads / the IRQ line after each clock.
module tb_gb_timer_accurate;

  localparam logic [15:0] ADiv  = 16'hFF04;
  localparam logic [15:0] ATima = 16'hFF05;
  localparam logic [15:0] ATma  = 16'hFF06;
  localparam logic [15:0] ATac  = 16'hFF07;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  int   cyc;

  gb_timer_accurate_if bus ();

  gb_timer_accurate dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    bit          is_irq;
    logic [15:0] addr;
    logic [7:0]  val;
  } exp_t;

  exp_t sb[$];

  task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    total++;
    if (obs !== exp_v) begin
      bad++;
      $display("FAIL %s: observed=%02h expected=%02h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wr_reg(input logic [15:0] addr, input logic [7:0] data);
    bus.a   = addr;
    bus.din = data;
    bus.wr  = 1'b1;
    tick();
    bus.wr  = 1'b0;
  endtask

  task automatic ack_tick();
    bus.int_tim_ack = 1'b1;
    tick();
    bus.int_tim_ack = 1'b0;
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) tick();
  endtask

  task automatic exp_rd(input string tag, input logic [15:0] addr, input logic [7:0] val);
    sb.push_back('{tag, 1'b0, addr, val});
  endtask

  task automatic exp_irq(input string tag, input logic v);
    sb.push_back('{tag, 1'b1, 16'h0000, {7'b0, v}});
  endtask

  // Compare all queued expectations; at most a few per clock period.
  task automatic drain();
    exp_t e;
    logic [7:0] obs;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.is_irq) begin
        obs = {7'b0, bus.int_tim_req};
      end else begin
        bus.a = e.addr;
        #1;
        obs = bus.dout;
      end
      check_val(e.tag, obs, e.val);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Reset, load TMA/TIMA, zero the divider (cyc=0), then enable TAC (cyc=1).
  task automatic setup(input logic [7:0] tima, input logic [7:0] tma);
    do_reset();
    wr_reg(ATma, tma);
    wr_reg(ATima, tima);
    wr_reg(ADiv, 8'h00);
    cyc = 0;
    wr_reg(ATac, 8'h05);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    total = 0;
    bad   = 0;
    cyc   = 0;
    rst   = 1'b1;
    bus.a = 16'h0000;
    bus.din = 8'h00;
    bus.wr = 1'b0;
    bus.int_tim_ack = 1'b0;

    // Reset state
    do_reset();
    exp_rd("rst_div", ADiv, 8'h00);
    exp_rd("rst_tima", ATima, 8'h00);
    exp_rd("rst_tma", ATma, 8'h00);
    exp_rd("rst_tac", ATac, 8'hF8);
    exp_irq("rst_irq", 1'b0);
    drain();

    // Two increments 16 clks apart, overflow, 4 clks of 00, then reload + IRQ
    setup(8'hFE, 8'h80);
    wait_cyc(17);
    exp_rd("t1_inc1", ATima, 8'hFF);
    drain();
    wait_cyc(32);
    exp_rd("t1_pre_ovf", ATima, 8'hFF);
    drain();
    wait_cyc(33);
    exp_rd("t1_ovf0", ATima, 8'h00);
    exp_irq("t1_ovf0_irq", 1'b0);
    drain();
    wait_cyc(36);
    exp_rd("t1_ovf3", ATima, 8'h00);
    exp_irq("t1_ovf3_irq", 1'b0);
    drain();
    wait_cyc(37);
    exp_rd("t1_reload", ATima, 8'h80);
    exp_irq("t1_reload_irq", 1'b1);
    drain();
    // Ack for one clk clears the request
    ack_tick();
    exp_irq("t5_ack_clr", 1'b0);
    exp_rd("t5_tima_hold", ATima, 8'h80);
    drain();

    // TIMA write two clks into OVF cancels the reload
    setup(8'hFF, 8'h80);
    wait_cyc(17);
    exp_rd("t2_ovf", ATima, 8'h00);
    drain();
    wait_cyc(18);
    wr_reg(ATima, 8'h33);
    exp_rd("t2_wr", ATima, 8'h33);
    drain();
    wait_cyc(24);
    exp_rd("t2_no_reload", ATima, 8'h33);
    exp_irq("t2_no_irq", 1'b0);
    drain();

    // TMA write on the RELOAD clk forwards into TIMA, then TIMA write lands
    setup(8'hFF, 8'h80);
    wait_cyc(21);
    exp_rd("t3a_reload", ATima, 8'h80);
    drain();
    wr_reg(ATma, 8'h55);
    exp_rd("t3a_fwd_tima", ATima, 8'h55);
    exp_rd("t3a_fwd_tma", ATma, 8'h55);
    drain();
    wr_reg(ATima, 8'h77);
    exp_rd("t3a_tima_wr", ATima, 8'h77);
    drain();

    // TIMA write on the RELOAD clk is ignored
    setup(8'hFF, 8'h80);
    wait_cyc(21);
    wr_reg(ATima, 8'h11);
    exp_rd("t3b_ignored", ATima, 8'h80);
    drain();

    // DIV write while div[3]=1 glitches TIMA by +1
    setup(8'h10, 8'h00);
    wait_cyc(264);
    exp_rd("t4_div_pre", ADiv, 8'h01);
    exp_rd("t4_tima_pre", ATima, 8'h20);
    drain();
    wr_reg(ADiv, 8'hAB);
    exp_rd("t4_div_clr", ADiv, 8'h00);
    exp_rd("t4_tima_mid", ATima, 8'h20);
    drain();
    tick();
    exp_rd("t4_div_glitch", ATima, 8'h21);
    drain();

    // TAC 05->01 while div[3]=1 glitches TIMA by +1, then timer stays off
    setup(8'h40, 8'h00);
    wait_cyc(10);
    wr_reg(ATac, 8'h01);
    exp_rd("t4b_tac", ATac, 8'hF9);
    exp_rd("t4b_tima_mid", ATima, 8'h40);
    drain();
    tick();
    exp_rd("t4b_glitch", ATima, 8'h41);
    drain();
    wait_cyc(40);
    exp_rd("t4b_stopped", ATima, 8'h41);
    drain();

    // Ack coincident with a new reload keeps the request set
    setup(8'hFF, 8'h80);
    wait_cyc(20);
    ack_tick();
    exp_irq("t5b_set_wins", 1'b1);
    exp_rd("t5b_tima", ATima, 8'h80);
    drain();
    ack_tick();
    exp_irq("t5b_ack_clr", 1'b0);
    drain();

    // Reset mid-overflow aborts the reload
    setup(8'hFF, 8'h80);
    wait_cyc(18);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_rd("t6_tma", ATma, 8'h00);
    exp_rd("t6_tac", ATac, 8'hF8);
    exp_rd("t6_tima", ATima, 8'h00);
    exp_irq("t6_irq", 1'b0);
    drain();
    wait_cyc(26);
    exp_rd("t6_no_reload", ATima, 8'h00);
    exp_irq("t6_no_irq", 1'b0);
    exp_rd("t6_unmapped", 16'hFF08, 8'hFF);
    exp_rd("t6_below", 16'hFF03, 8'hFF);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
